// File: rtl/estagio_busca.sv
// Instruction-fetch stage.
// Owns the PC register and steps it by PC_STEP. The current PC drives the instruction-memory
// request, and the returned word is captured into a one-entry IF/ID output register.
// A redirect from downstream reloads the PC and flushes the stage. If a request is still in
// flight when the redirect arrives, the stage enters DRAIN and discards that one response.
//
// Ports:
//   clock, reset                 single clock; synchronous active-high reset
//   redirect_valid, redirect_pc  1-cycle redirect pulse and its target (bits [1:0] ignored)
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_ack, imem_rdata         response strobe and instruction word (same cycle)
//   id_valid, id_ready           IF/ID handshake towards decode
//   id_instr, id_pc, id_pc4      fetched instruction, its address, and address + PC_STEP
module estagio_busca #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam logic [31:0] Step = 32'(PC_STEP);

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;

    logic        slot_free;
    logic        resp;
    logic [31:0] pc_next_seq;
    logic [31:0] redirect_target;

    // Request side
    always_comb begin
        slot_free = !id_valid_q || id_ready;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (state_q == StDrain) begin
            // The dropped request must still be completed at its original address.
            imem_req  = 1'b1;
            imem_addr = drain_addr_q;
        end else begin
            imem_req  = slot_free;
            imem_addr = pc_q;
        end
        if (reset) begin
            imem_req = 1'b0;
        end
    end

    // An ack only counts while a request is up; a stray ack is ignored.
    assign resp            = imem_req && imem_ack;
    assign pc_next_seq     = pc_q + Step;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;

        if (redirect_valid) begin
            // A redirect takes priority over any response arriving in the same cycle.
            pc_d       = redirect_target;
            id_valid_d = 1'b0;
            case (state_q)
                StFetch: begin
                    if (imem_req && !imem_ack) begin
                        drain_addr_d = imem_addr;
                        state_d      = StDrain;
                    end
                end
                StDrain: begin
                    if (resp) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end else begin
            case (state_q)
                StFetch: begin
                    if (resp) begin
                        id_instr_d = imem_rdata;
                        id_pc_d    = pc_q;
                        id_pc4_d   = pc_next_seq;
                        id_valid_d = 1'b1;
                        pc_d       = pc_next_seq;
                    end else if (id_valid_q && id_ready) begin
                        id_valid_d = 1'b0;
                    end
                end
                StDrain: begin
                    if (resp) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'h0;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_pc4   = id_pc4_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: directed scenarios followed by randomized traffic. The reference
// model views the stage as a stream. Instructions delivered to decode must follow consecutive
// addresses from the last reset or redirect target. The memory protocol and backpressure
// rules are checked every cycle.
module tb_estagio_busca;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    always #5 clock = ~clock;

    estagio_busca #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Memory model state
    int unsigned mem_wait = 0;
    int unsigned mem_cnt  = 0;
    bit          mem_rand = 1'b0;

    // Reference / protocol tracking
    logic [31:0] exp_pc     = 32'h0;
    int unsigned delivered  = 0;
    bit          out_prev   = 1'b0;
    logic [31:0] addr_prev  = 32'h0;
    bit          bp_prev    = 1'b0;
    logic [31:0] held_pc    = 32'h0;
    logic [31:0] held_instr = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic monitor();
        if (reset) begin
            exp_pc = 32'h0;
            return;
        end
        if (out_prev) begin
            check_eq("req_hold", {31'b0, imem_req}, 32'd1);
            check_eq("addr_hold", imem_addr, addr_prev);
        end
        if (bp_prev) begin
            check_eq("bp_valid", {31'b0, id_valid}, 32'd1);
            check_eq("bp_pc", id_pc, held_pc);
            check_eq("bp_instr", id_instr, held_instr);
        end
        if (id_valid && !id_ready) begin
            check_eq("bp_noreq", {31'b0, imem_req}, 32'd0);
        end
        if (id_valid && id_ready) begin
            check_eq("stream_pc", id_pc, exp_pc);
            check_eq("stream_instr", id_instr, mem_word(exp_pc));
            check_eq("stream_pc4", id_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc & ~32'd3;
        end
    endtask

    // Let the inputs settle, answer as the memory, then run the per-cycle checks.
    task automatic settle();
        #1;
        if (imem_req) begin
            if (mem_rand) imem_ack = ($urandom_range(0, 1) == 1);
            else          imem_ack = (mem_cnt >= mem_wait);
            imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        end else begin
            // Occasional stray ack without a request; the stage must ignore it.
            imem_ack   = mem_rand && ($urandom_range(0, 19) == 0);
            imem_rdata = $urandom;
        end
        #1;
        monitor();
    endtask

    task automatic advance();
        out_prev   = !reset && imem_req && !imem_ack;
        addr_prev  = imem_addr;
        bp_prev    = !reset && id_valid && !id_ready && !redirect_valid;
        held_pc    = id_pc;
        held_instr = id_instr;
        if (reset || !imem_req || imem_ack) mem_cnt = 0;
        else                                mem_cnt++;
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        settle();
        advance();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        id_ready       = 1'b1;

        // 1. Reset
        settle();
        advance();
        settle();
        check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
        check_eq("rst_pc", id_pc, 32'h0);
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        advance();
        reset = 1'b0;
        settle();
        check_eq("first_req", {31'b0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        advance();

        // 2. Zero-wait streaming
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("zw_valid", {31'b0, id_valid}, 32'd1);
            check_eq("zw_pc", id_pc, 32'(4 * i));
            check_eq("zw_pc4", id_pc4, 32'(4 * i + 4));
            check_eq("zw_instr", id_instr, mem_word(32'(4 * i)));
            advance();
        end

        // 3. Two wait states
        mem_wait = 2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("ws_req", {31'b0, imem_req}, 32'd1);
            check_eq("ws_addr", imem_addr, 32'h0);
            check_eq("ws_valid", {31'b0, id_valid}, 32'd0);
            advance();
        end
        settle();
        check_eq("ws_valid_after", {31'b0, id_valid}, 32'd1);
        check_eq("ws_pc", id_pc, 32'h0);
        check_eq("ws_next_addr", imem_addr, 32'h4);
        advance();

        // 4. Backpressure
        mem_wait = 0;
        do_reset();
        settle();
        advance();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq("bpd_req", {31'b0, imem_req}, 32'd0);
            check_eq("bpd_valid", {31'b0, id_valid}, 32'd1);
            check_eq("bpd_pc", id_pc, 32'h0);
            check_eq("bpd_instr", id_instr, mem_word(32'h0));
            advance();
        end
        id_ready = 1'b1;
        settle();
        check_eq("bp_release_req", {31'b0, imem_req}, 32'd1);
        check_eq("bp_release_addr", imem_addr, 32'h4);
        advance();

        // 5. Redirect while a request is waiting
        do_reset();
        settle();
        advance();
        settle();
        advance();
        mem_wait       = 5;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        settle();
        check_eq("rd_wait_addr", imem_addr, 32'h8);
        check_eq("rd_wait_ack", {31'b0, imem_ack}, 32'd0);
        advance();
        mem_wait = 1;
        settle();
        check_eq("drain_req", {31'b0, imem_req}, 32'd1);
        check_eq("drain_addr", imem_addr, 32'h8);
        check_eq("drain_valid", {31'b0, id_valid}, 32'd0);
        advance();
        settle();
        check_eq("drain_drop", {31'b0, id_valid}, 32'd0);
        check_eq("drain_next_addr", imem_addr, 32'h100);
        check_eq("drain_next_req", {31'b0, imem_req}, 32'd1);
        mem_wait = 0;
        advance();
        settle();
        advance();

        // 6. Redirect with ack in the same cycle, then PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        settle();
        check_eq("sc_ack", {31'b0, imem_ack}, 32'd1);
        check_eq("sc_pc", id_pc, 32'h100);
        advance();
        settle();
        check_eq("sc_drop", {31'b0, id_valid}, 32'd0);
        check_eq("sc_target", imem_addr, 32'hFFFF_FFFC);
        advance();
        settle();
        check_eq("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", id_pc4, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'h0);
        advance();

        // Randomized traffic
        mem_rand = 1'b1;
        do_reset();
        delivered = 0;
        for (int c = 0; c < 4000; c++) begin
            reset          = ($urandom_range(0, 599) == 0);
            id_ready       = out_prev ? 1'b1 : ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ?
                             (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            settle();
            advance();
        end
        reset = 1'b0;
        check_eq("progress", {31'b0, (delivered > 500)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
